mr3_spot_conditioner: RTL and testbench
=======================================

# mr3_spot_conditioner

Upstream conditioning stage for the junction controller. Converts the raw, asynchronous MR3 presence sensor into the clean `mr3_spot` request the controller consumes. It synchronises and debounces the sensor, then holds the request for a bounded dwell. After each dwell it enforces a cooldown so a stuck or chattering sensor cannot starve road2/road3. It also keeps a saturating count of granted requests for maintenance readout.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to change the debounced level (1..255).
- `MIN_HOLD_CYCLES`, default 16: minimum cycles `mr3_spot` stays high once asserted (1..255).
- `MAX_HOLD_CYCLES`, default 64: maximum cycles `mr3_spot` stays high; forced release at this bound (`MIN_HOLD_CYCLES`..255).
- `COOLDOWN_CYCLES`, default 8: cycles `mr3_spot` is held low after every release (1..255).

Ports:
- `clk`, input, 1: single clock; all state on rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `sensor_raw`, input, 1: raw MR3 presence sensor, asynchronous to `clk`, may bounce.
- `clear_count`, input, 1: synchronous; zeroes `request_count`.
- `mr3_spot`, output, 1: registered, conditioned request to the controller.
- `cooldown_active`, output, 1: registered; high while in COOLDOWN.
- `forced_release`, output, 1: registered one-cycle pulse when a hold ends on `MAX_HOLD_CYCLES`.
- `request_count`, output, 8: registered count of IDLE->HOLD transitions, saturates at 255.

## Operation
- Synchroniser: two flops, `sensor_raw` -> `s1` -> `s2`. Both reset to 0.
- Debouncer:
  - `deb` resets to 0. An 8-bit counter increments each cycle `s2 != deb` and clears whenever `s2 == deb`.
  - When the counter would reach `DEBOUNCE_CYCLES`, `deb <= s2` and the counter clears.
- FSM, 2-bit state, resets to IDLE:
  - IDLE: `mr3_spot=0`. If `deb==1`, go to HOLD, clear `hold_timer`, and increment `request_count` (saturating).
  - HOLD: `mr3_spot=1`, `hold_timer` increments each cycle.
    - If `hold_timer == MAX_HOLD_CYCLES-1`, go to COOLDOWN and pulse `forced_release`.
    - Else if `hold_timer >= MIN_HOLD_CYCLES-1` and `deb==0`, go to COOLDOWN with no pulse.
    - When both conditions hold, the MAX rule wins and the pulse fires.
  - COOLDOWN: `mr3_spot=0`, `cooldown_active=1`, `deb` is ignored. After exactly `COOLDOWN_CYCLES` cycles in COOLDOWN, go to IDLE.
  - The fourth state encoding is illegal and recovers to IDLE on the next edge with all outputs 0.
- Outputs are registered alongside the state, so `mr3_spot` and `cooldown_active` reflect the current state with no combinational path from `sensor_raw`.
- `request_count`:
  - `clear_count` has priority over the increment in the same cycle; the result is 0.
  - At 255, further grants leave it at 255.
- Parameter errors (MIN > MAX, or any value of 0) are caught by an elaboration-time check.

## Timing
- Reset values: `mr3_spot=0`, `cooldown_active=0`, `forced_release=0`, `request_count=0`, state IDLE, `s1=s2=deb=0`, all counters 0. Reset asserts `mr3_spot=0` asynchronously, including mid-HOLD.
- Assert latency: `sensor_raw` rises and stays high before edge 0.
  - `s2=1` after edge 1.
  - `deb=1` after edge `1+DEBOUNCE_CYCLES`.
  - `mr3_spot=1` after edge `2+DEBOUNCE_CYCLES` (edge 6 at defaults).
- Release latency: after MIN is satisfied, `deb` falling causes `mr3_spot` to fall on the next edge.
- Dwell length: `mr3_spot` is high for exactly `clamp(T, MIN_HOLD_CYCLES, MAX_HOLD_CYCLES)` cycles, where T is the number of HOLD cycles up to and including the first cycle in which `deb` samples 0.
- Stuck-high sensor: steady cycle of `MAX_HOLD_CYCLES` high, then `COOLDOWN_CYCLES+1` low (COOLDOWN plus one IDLE cycle). Defaults give 64 high, 9 low.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles never change `deb`.
- Sensor activity during COOLDOWN still updates `deb`, but is acted on only from IDLE.

## Test plan
- Reset, then `sensor_raw=1` held for 10 cycles, then 0 -> `mr3_spot` rises after edge 6, stays high exactly 16 cycles, then `cooldown_active` is high for 8 cycles; `request_count=1`; `forced_release` never pulses.
- `sensor_raw` toggles every 2 cycles for 40 cycles -> `deb` stays 0, `mr3_spot` stays 0, `request_count=0`.
- `sensor_raw` held high for 200 cycles -> `mr3_spot` shows 64 high / 9 low repeating; `forced_release` pulses one cycle at each fall; `request_count` increments once per period.
- Sensor high for 30 cycles (`deb` high for 30) -> `mr3_spot` high for 30 cycles plus debounce skew, bounded by 16..64; no pulse.
- `reset` asserted mid-HOLD at hold cycle 10 -> `mr3_spot` drops within the same cycle with no clock edge; after deassertion all outputs are 0 and state is IDLE.
- Drive 256 grants, then `clear_count` on the same cycle as a grant -> `request_count` sits at 255, then reads 0.

Source files
------------

// File: rtl/mr3_spot_conditioner_if.sv
// Signal bundle between the MR3 spot conditioner and its driver/consumer.
// The slave side is the conditioner; the master side drives the sensor and the clear strobe.
interface mr3_spot_conditioner_if;
   logic       sensor_raw;
   logic       clear_count;
   logic       mr3_spot;
   logic       cooldown_active;
   logic       forced_release;
   logic [7:0] request_count;

   modport master (
      output sensor_raw,
      output clear_count,
      input  mr3_spot,
      input  cooldown_active,
      input  forced_release,
      input  request_count
   );

   modport slave (
      input  sensor_raw,
      input  clear_count,
      output mr3_spot,
      output cooldown_active,
      output forced_release,
      output request_count
   );
endinterface

// File: rtl/mr3_spot_conditioner.sv
// MR3 presence conditioner: synchronise, debounce, bounded-dwell request with cooldown
// and a saturating grant counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | request low, waiting for debounced sensor high
//   ST_HOLD  | request high, dwell timer running (MIN..MAX cycles)
//   ST_COOL  | request low for COOLDOWN_CYCLES, sensor ignored
//   ST_BAD   | illegal encoding, recovers to ST_IDLE
module mr3_spot_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MIN_HOLD_CYCLES = 16,
   parameter int MAX_HOLD_CYCLES = 64,
   parameter int COOLDOWN_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   mr3_spot_conditioner_if.slave bus
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
       MIN_HOLD_CYCLES < 1 || MIN_HOLD_CYCLES > 255 ||
       MAX_HOLD_CYCLES < MIN_HOLD_CYCLES || MAX_HOLD_CYCLES > 255 ||
       COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > 255) begin : g_param_check
      $error("mr3_spot_conditioner: illegal parameter combination");
   end

   localparam logic [7:0] L_DEB     = 8'(DEBOUNCE_CYCLES);
   localparam logic [7:0] L_MIN_M1  = 8'(MIN_HOLD_CYCLES - 1);
   localparam logic [7:0] L_MAX_M1  = 8'(MAX_HOLD_CYCLES - 1);
   localparam logic [7:0] L_COOL_M1 = 8'(COOLDOWN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HOLD = 2'b01,
      ST_COOL = 2'b10,
      ST_BAD  = 2'b11
   } state_t;

   logic       r_s1;
   logic       r_s2;
   logic       r_deb;
   logic [7:0] r_deb_cnt;
   logic [7:0] w_deb_cnt_inc;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_hold_timer;
   logic [7:0] w_hold_nxt;
   logic [7:0] r_cool_timer;
   logic [7:0] w_cool_nxt;
   logic       w_grant;
   logic       w_force;

   logic       r_mr3_spot;
   logic       r_cooldown_active;
   logic       r_forced_release;
   logic [7:0] r_request_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= bus.sensor_raw;
         r_s2 <= r_s1;
      end
   end

   assign w_deb_cnt_inc = r_deb_cnt + 8'd1;

   // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_deb     <= 1'b0;
         r_deb_cnt <= 8'd0;
      end else if (r_s2 == r_deb) begin
         r_deb_cnt <= 8'd0;
      end else if (w_deb_cnt_inc == L_DEB) begin
         r_deb     <= r_s2;
         r_deb_cnt <= 8'd0;
      end else begin
         r_deb_cnt <= w_deb_cnt_inc;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_timer;
      w_cool_nxt  = r_cool_timer;
      w_grant     = 1'b0;
      w_force     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_deb) begin
               w_state_nxt = ST_HOLD;
               w_hold_nxt  = 8'd0;
               w_grant     = 1'b1;
            end
         end
         ST_HOLD: begin
            // The MAX bound is tested first so it wins when both releases coincide.
            if (r_hold_timer == L_MAX_M1) begin
               w_state_nxt = ST_COOL;
               w_cool_nxt  = 8'd0;
               w_force     = 1'b1;
            end else if (r_hold_timer >= L_MIN_M1 && !r_deb) begin
               w_state_nxt = ST_COOL;
               w_cool_nxt  = 8'd0;
            end else begin
               w_hold_nxt  = r_hold_timer + 8'd1;
            end
         end
         ST_COOL: begin
            if (r_cool_timer == L_COOL_M1) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cool_nxt  = r_cool_timer + 8'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = 8'd0;
            w_cool_nxt  = 8'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state           <= ST_IDLE;
         r_hold_timer      <= 8'd0;
         r_cool_timer      <= 8'd0;
         r_mr3_spot        <= 1'b0;
         r_cooldown_active <= 1'b0;
         r_forced_release  <= 1'b0;
      end else begin
         r_state           <= w_state_nxt;
         r_hold_timer      <= w_hold_nxt;
         r_cool_timer      <= w_cool_nxt;
         r_mr3_spot        <= (w_state_nxt == ST_HOLD);
         r_cooldown_active <= (w_state_nxt == ST_COOL);
         r_forced_release  <= w_force;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_request_count <= 8'd0;
      end else if (bus.clear_count) begin
         r_request_count <= 8'd0;
      end else if (w_grant && r_request_count != 8'hFF) begin
         r_request_count <= r_request_count + 8'd1;
      end
   end

   assign bus.mr3_spot        = r_mr3_spot;
   assign bus.cooldown_active = r_cooldown_active;
   assign bus.forced_release  = r_forced_release;
   assign bus.request_count   = r_request_count;

endmodule

// File: tb/tb_mr3_spot_conditioner.sv
// Directed bench for mr3_spot_conditioner at default parameters; expected values are
// hand-derived edge numbers and dwell lengths.
module tb_mr3_spot_conditioner;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   mr3_spot_conditioner_if bus_if ();

   mr3_spot_conditioner dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int first_rise, first_fall, gap0, run0, run1, n_runs;
   int hi_cnt, cool_cnt, frc_cnt, frc_bad, run_start, last_fall;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic reset_dut();
      reset                = 1'b1;
      bus_if.sensor_raw    = 1'b0;
      bus_if.clear_count   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic sens(input int e, input int hi_len, input bit toggle);
      return (e < hi_len) && (!toggle || ((e / 2) % 2 == 0));
   endfunction

   // Edge 0 is the first rising edge after this call; the sensor for edge e is driven
   // between edges e-1 and e, and outputs are sampled 1 time unit after each edge.
   task automatic run_pattern(input int n, input int hi_len, input bit toggle);
      logic prev;
      logic spot;
      first_rise = -1; first_fall = -1; gap0 = -1; run0 = -1; run1 = -1; n_runs = 0;
      hi_cnt = 0; cool_cnt = 0; frc_cnt = 0; frc_bad = 0; run_start = 0; last_fall = -1;
      prev = 1'b0;
      bus_if.sensor_raw = sens(0, hi_len, toggle);
      for (int e = 0; e < n; e++) begin
         @(posedge clk);
         #1;
         spot = bus_if.mr3_spot;
         if (spot && !prev) begin
            if (first_rise < 0) first_rise = e;
            if (last_fall >= 0 && gap0 < 0) gap0 = e - last_fall;
            run_start = e;
         end
         if (!spot && prev) begin
            if (n_runs == 0) run0 = e - run_start;
            else if (n_runs == 1) run1 = e - run_start;
            n_runs++;
            last_fall = e;
            if (first_fall < 0) first_fall = e;
         end
         hi_cnt   += int'(spot);
         cool_cnt += int'(bus_if.cooldown_active);
         if (bus_if.forced_release) begin
            frc_cnt++;
            if (!(prev && !spot)) frc_bad++;
         end
         prev = spot;
         bus_if.sensor_raw = sens(e + 1, hi_len, toggle);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      // reset state
      reset_dut();
      chk("rst_spot",  int'(bus_if.mr3_spot), 0);
      chk("rst_cool",  int'(bus_if.cooldown_active), 0);
      chk("rst_frc",   int'(bus_if.forced_release), 0);
      chk("rst_count", int'(bus_if.request_count), 0);

      // 10-cycle press: rise at edge 6, MIN dwell of 16, 8 cooldown cycles
      run_pattern(45, 10, 1'b0);
      chk("p10_rise",  first_rise, 6);
      chk("p10_run",   run0, 16);
      chk("p10_fall",  first_fall, 22);
      chk("p10_cool",  cool_cnt, 8);
      chk("p10_frc",   frc_cnt, 0);
      chk("p10_count", int'(bus_if.request_count), 1);

      // chatter every 2 cycles never debounces
      reset_dut();
      run_pattern(60, 40, 1'b1);
      chk("chat_hi",    hi_cnt, 0);
      chk("chat_count", int'(bus_if.request_count), 0);

      // glitch of 3 cycles is filtered, 4 cycles is accepted and clamped to MIN
      reset_dut();
      run_pattern(40, 3, 1'b0);
      chk("g3_hi",    hi_cnt, 0);
      chk("g3_count", int'(bus_if.request_count), 0);
      reset_dut();
      run_pattern(40, 4, 1'b0);
      chk("g4_run",   run0, 16);
      chk("g4_count", int'(bus_if.request_count), 1);

      // stuck high: 64 high / 9 low, forced pulse on each fall
      reset_dut();
      run_pattern(200, 200, 1'b0);
      chk("stk_rise",  first_rise, 6);
      chk("stk_run0",  run0, 64);
      chk("stk_gap",   gap0, 9);
      chk("stk_run1",  run1, 64);
      chk("stk_frc",   frc_cnt, 2);
      chk("stk_frcok", frc_bad, 0);
      chk("stk_hi",    hi_cnt, 176);
      chk("stk_cool",  cool_cnt, 16);
      chk("stk_count", int'(bus_if.request_count), 3);

      // 30-cycle press tracks the sensor
      reset_dut();
      run_pattern(60, 30, 1'b0);
      chk("p30_run", run0, 30);
      chk("p30_frc", frc_cnt, 0);

      // one below MAX releases normally; exactly MAX coincides and the pulse wins
      reset_dut();
      run_pattern(90, 63, 1'b0);
      chk("p63_run", run0, 63);
      chk("p63_frc", frc_cnt, 0);
      reset_dut();
      run_pattern(90, 64, 1'b0);
      chk("p64_run", run0, 64);
      chk("p64_frc", frc_cnt, 1);

      // async reset mid-HOLD at hold cycle 10
      reset_dut();
      run_pattern(17, 100, 1'b0);
      chk("mid_pre_spot", int'(bus_if.mr3_spot), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_async_spot", int'(bus_if.mr3_spot), 0);
      bus_if.sensor_raw = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      run_pattern(20, 0, 1'b0);
      chk("mid_post_hi",    hi_cnt, 0);
      chk("mid_post_cool",  cool_cnt, 0);
      chk("mid_post_frc",   frc_cnt, 0);
      chk("mid_post_count", int'(bus_if.request_count), 0);

      // saturation and clear-vs-grant priority; grant k lands on edge 6+73k
      reset_dut();
      begin
         int e_255;
         int e_sat;
         int e_clr;
         e_255 = 6 + 73 * 254;
         e_sat = 6 + 73 * 255;
         e_clr = 6 + 73 * 256;
         bus_if.sensor_raw  = 1'b1;
         bus_if.clear_count = 1'b0;
         for (int e = 0; e <= e_clr; e++) begin
            bus_if.clear_count = (e == e_clr);
            @(posedge clk);
            #1;
            if (e == e_255 - 1) chk("sat_254", int'(bus_if.request_count), 254);
            if (e == e_255)     chk("sat_255", int'(bus_if.request_count), 255);
            if (e == e_sat) begin
               chk("sat_hold",      int'(bus_if.request_count), 255);
               chk("sat_hold_spot", int'(bus_if.mr3_spot), 1);
            end
            if (e == e_clr) begin
               chk("clr_count", int'(bus_if.request_count), 0);
               chk("clr_spot",  int'(bus_if.mr3_spot), 1);
            end
         end
         bus_if.clear_count = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
